ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage; consumes operands and function code from the ID/EX pipeline register outputs.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers.
- Drives a stall back to IF/ID and ID/EX while an operation is in flight.
- Shift-add multiply, restoring divide, one bit per clock.

---
 rtl/ex_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module      : ex_muldiv_unit
// Description : EX-stage iterative multiply/divide unit that owns HI/LO.
//               Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);
  localparam logic [2:0]    c_OP_MULT  = 3'd1;
  localparam logic [2:0]    c_OP_MULTU = 3'd2;
  localparam logic [2:0]    c_OP_DIV   = 3'd3;
  localparam logic [2:0]    c_OP_DIVU  = 3'd4;
  localparam logic [2:0]    c_OP_MTHI  = 3'd5;
  localparam logic [2:0]    c_OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_prod;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_is_div, r_neg_res, r_neg_rem, r_done;

  logic                 w_is_mul, w_is_div, w_is_signed, w_accept, w_div_zero, w_mul_fast;
  logic [WIDTH-1:0]     w_a_abs, w_b_abs;
  logic [WIDTH:0]       w_mul_sum, w_div_shift, w_div_diff;
  logic                 w_div_ge;
  logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod_fix, w_mul_init;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  assign w_is_mul    = (op == c_OP_MULT) || (op == c_OP_MULTU);
  assign w_is_div    = (op == c_OP_DIV)  || (op == c_OP_DIVU);
  assign w_is_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
  assign w_accept    = (r_state == ST_IDLE) && start && (w_is_mul || w_is_div) && !flush;
  assign w_div_zero  = w_is_div && (rt_data == '0);
  assign w_a_abs     = (w_is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign w_b_abs     = (w_is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

`ifdef MULDIV_FAST_MUL_EN
  assign w_mul_fast = w_is_mul;
  assign w_mul_init = {{WIDTH{1'b0}}, w_a_abs} * {{WIDTH{1'b0}}, w_b_abs};
`else
  assign w_mul_fast = 1'b0;
  assign w_mul_init = {{WIDTH{1'b0}}, w_b_abs};
`endif

  // Shift-add: upper half accumulates the multiplicand, multiplier consumed from bit 0
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts in quotient bits
  assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_next  = w_div_ge ? {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_res ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = (w_div_zero || w_mul_fast) ? ST_FIX : ST_BUSY;
      ST_BUSY: begin
        if (flush)                 w_state_next = ST_IDLE;
        else if (r_count == c_LAST) w_state_next = ST_FIX;
      end
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_prod    <= '0;
      r_opnd    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start && !flush && op == c_OP_MTHI) r_hi <= rs_data;
        if (start && !flush && op == c_OP_MTLO) r_lo <= rs_data;
        if (w_accept) begin
          r_count  <= '0;
          r_is_div <= w_is_div;
          r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
          // Divide by zero skips iteration and writes the raw dividend / all ones uncorrected
          if (w_div_zero) begin
            r_prod    <= {rs_data, {WIDTH{1'b1}}};
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
          end else begin
            r_prod    <= w_is_div ? {{WIDTH{1'b0}}, w_a_abs} : w_mul_init;
            r_neg_res <= w_is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            r_neg_rem <= w_is_signed && rs_data[WIDTH-1];
          end
        end
      end else if (r_state == ST_BUSY) begin
        if (!flush) begin
          r_count <= r_count + CW'(1);
          r_prod  <= r_is_div ? w_div_next : w_mul_next;
        end
      end else if (r_state == ST_FIX) begin
        if (!flush) begin
          if (r_is_div) {r_hi, r_lo} <= {w_rem_fix, w_quo_fix};
          else          {r_hi, r_lo} <= w_prod_fix;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state != ST_IDLE) || w_accept;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed scoreboard bench for ex_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] rs_data = '0;
  logic [WIDTH-1:0] rt_data = '0;
  logic             flush = 1'b0;
  logic             busy, done;
  logic [WIDTH-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic [63:0] r_last_hilo = '0;

  ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from native SystemVerilog arithmetic, returned as {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: return sa * sb64;
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb64;
        r = sa % sb64;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int bcyc;
    int exp_cyc;
    bit seen;
    logic [63:0] exp;
    exp_cyc = WIDTH + 2;
    if ((o == 3'd3 || o == 3'd4) && b == 0) exp_cyc = 2;
`ifdef MULDIV_FAST_MUL_EN
    if (o == 3'd1 || o == 3'd2) exp_cyc = 2;
`endif
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    sb.push_back(model(o, a, b));
    #1 check({tag, "_busy_start"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    bcyc = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) bcyc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(bcyc), 64'(exp_cyc));
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    exp = sb.pop_front();
    if (seen) begin
      check({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
      check({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    end
    r_last_hilo = exp;
    @(negedge clk);
    check({tag, "_done_single"}, 64'(done), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 3'd4, 32'd100, 32'd7);
    run_op("div_zero", 3'd3, 32'h1234_5678, 32'd0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_negneg", 3'd3, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
    for (int k = 0; k < 2; k++) begin
      run_op("mult_rnd", 3'd1, $urandom, $urandom);
      run_op("div_rnd", 3'd3, $urandom, $urandom_range(1, 65535));
      run_op("divu_rnd", 3'd4, $urandom, $urandom);
    end

    // MTHI then MTLO on consecutive edges, no stall
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs_data = 32'hA5A5_A5A5;
    #1 check("mthi_busy", 64'(busy), 64'd0);
    @(negedge clk);
    op = 3'd6; rs_data = 32'h5A5A_5A5A;
    #1 check("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    check("mtlo_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    check("mtlo_lo", 64'(lo), 64'h5A5A_5A5A);
    check("mt_done", 64'(done), 64'd0);

    // Flush while iterating: HI/LO retained, no done
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_data = 32'd1000; rt_data = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'hA5A5_A5A5);
    check("flush_lo", 64'(lo), 64'h5A5A_5A5A);
    begin
      bit any_done;
      any_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) any_done = 1;
      end
      check("flush_no_done", 64'(any_done), 64'd0);
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_data = 32'd77; rt_data = 32'd5;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("rstmid_hi", 64'(hi), 64'd0);
    check("rstmid_lo", 64'(lo), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_idle", 64'(busy), 64'd0);

    // Unit still operational after reset
    run_op("divu_post", 3'd4, 32'd100, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
